// File: rtl/ldpc_llr_loader.sv
// LLR loader for ldpc_core.
// Accepts a valid/ready stream of P signed samples per beat and clips each one
// symmetrically to data_w bits. It assembles one codeword of R*D LLRs in a flat
// buffer, then holds that frame under a frame_valid/frame_ack handshake.
module ldpc_llr_loader #(
    parameter int R      = 24,
    parameter int D      = 96,
    parameter int data_w = 8,
    parameter int in_w   = 12,
    parameter int P      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [P*in_w-1:0]         in_data,
    input  logic                      in_last,
    output logic [R*D*data_w-1:0]     llr,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic                      frame_err,
    output logic [15:0]               sat_cnt
);

    localparam int BEATS = (R * D) / P;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CS_W  = $clog2(P + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Symmetric clip limits. The most negative data_w code is never produced,
    // so the core sees a range that negates without overflow.
    localparam logic signed [in_w-1:0] POS_LIM = in_w'((2 ** (data_w - 1)) - 1);
    localparam logic signed [in_w-1:0] NEG_LIM = -POS_LIM;
    localparam logic [data_w-1:0]      POS_OUT = POS_LIM[data_w-1:0];
    localparam logic [data_w-1:0]      NEG_OUT = NEG_LIM[data_w-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic                      in_ready_reg;
    logic                      frame_valid_reg;
    logic                      frame_err_reg;
    logic [15:0]               sat_cnt_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [R*D*data_w-1:0]     llr_reg;

    logic [P*data_w-1:0]       sat_data;
    logic [P-1:0]              clip;
    logic [CS_W-1:0]           clip_sum;
    logic [16:0]               sat_sum;
    logic                      accept;
    logic                      last_beat;

    assign accept    = in_valid && in_ready_reg;
    assign last_beat = (cnt_reg == LAST_BEAT);

    // Per-lane saturation of one input sample to data_w bits.
    for (genvar gi = 0; gi < P; gi++) begin : g_sat
        logic signed [in_w-1:0] s;
        logic                   hit_hi;
        logic                   hit_lo;
        assign s      = $signed(in_data[gi*in_w +: in_w]);
        assign hit_hi = (s > POS_LIM);
        assign hit_lo = (s < NEG_LIM);
        assign clip[gi] = hit_hi | hit_lo;
        assign sat_data[gi*data_w +: data_w] = hit_hi ? POS_OUT :
                                               hit_lo ? NEG_OUT : s[data_w-1:0];
    end

    // Number of clipped lanes in the current beat, and the saturating total.
    always_comb begin
        clip_sum = '0;
        for (int j = 0; j < P; j++) begin
            clip_sum = clip_sum + CS_W'(clip[j]);
        end
        sat_sum = {1'b0, sat_cnt_reg} + 17'(clip_sum);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fill until the final beat, hold until acknowledged.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = FILL;
            FILL:    if (accept && last_beat) state_next = HOLD;
            HOLD:    if (frame_ack) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_reg    <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            in_ready_reg    <= (state_next == FILL);
            frame_valid_reg <= (state_next == HOLD);
        end
    end

    // Beat counter, framing error, saturation counter and frame buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            frame_err_reg <= 1'b0;
            sat_cnt_reg   <= '0;
            llr_reg       <= '0;
        end else if (accept) begin
            for (int j = 0; j < P; j++) begin
                llr_reg[(int'(cnt_reg) * P + j) * data_w +: data_w] <= sat_data[j*data_w +: data_w];
            end
            sat_cnt_reg <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            if (last_beat) begin
                // Frame is delivered regardless; a missing in_last only flags it.
                cnt_reg <= '0;
                if (!in_last) frame_err_reg <= 1'b1;
            end else if (in_last) begin
                // Early in_last: drop the partial frame and restart at beat 0.
                cnt_reg       <= '0;
                frame_err_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else if ((state_reg == HOLD) && frame_ack) begin
            cnt_reg       <= '0;
            frame_err_reg <= 1'b0;
        end
    end

    assign in_ready    = in_ready_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign sat_cnt     = sat_cnt_reg;
    assign llr         = llr_reg;

endmodule

// File: doc/ldpc_llr_loader.md
Name: ldpc_llr_loader

Overview:
Upstream stage of ldpc_core. It accepts channel LLRs as a beat-wise valid/ready stream of P signed samples per beat and saturates each sample from in_w to data_w bits. It assembles one full codeword of R*D LLRs into the flat bus that feeds the core's l input. It holds that frame stable under a frame_valid/frame_ack handshake while the core decodes.

Parameters:
R, 24, block columns of base matrix (matches core R)
D, 96, lifting size (matches core D)
data_w, 8, LLR width delivered to core
in_w, 12, signed input sample width (in_w >= data_w)
P, 8, samples per input beat; R*D must be a multiple of P
BEATS, R*D/P (derived, 288), beats per frame

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  loader can accept a beat
in_data  in  P*in_w  sample j at [j*in_w +: in_w], two's complement
in_last  in  1  marks final beat of a frame
llr  out  R*D*data_w  frame buffer; sample k at [k*data_w +: data_w]
frame_valid  out  1  llr holds a complete frame
frame_ack  in  1  core has captured the frame
frame_err  out  1  framing error on current/just-completed frame
sat_cnt  out  16  running count of saturated samples

Behaviour:
- Reset (rst low, async): state IDLE, in_ready=0, frame_valid=0, frame_err=0, sat_cnt=0, beat counter=0, llr all zeros.
- States: IDLE -> FILL unconditionally on the first clock after reset release. FILL -> HOLD on acceptance of beat BEATS-1. HOLD -> FILL on frame_ack=1.
- in_ready and frame_valid are registered outputs:
  - in_ready=1 exactly in FILL.
  - frame_valid=1 exactly in HOLD.
- Transfer occurs when in_valid && in_ready.
  - Beat b, sample j is written to index k = b*P+j.
  - Each sample is saturated symmetrically to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], i.e. -127..127 for data_w=8.
  - The code -2^(data_w-1) is never output.
  - In-range values pass unchanged, sign preserved.
- sat_cnt adds the number of clipped samples in each accepted beat (0..P). It saturates at 16'hFFFF and is never cleared except by reset.
- Beat counter increments per accepted beat and wraps to 0 on the final beat.
- Latency: the final beat is accepted at edge N. At edge N, in_ready falls and frame_valid rises, so both are visible after edge N.
- HOLD:
  - llr is frozen and in_data is ignored.
  - frame_ack sampled high at edge M sets frame_valid=0, in_ready=1, counter=0 and clears frame_err, all visible after edge M.
  - frame_ack is ignored outside HOLD.
- During FILL, llr changes beat by beat. The consumer samples llr only while frame_valid=1.
- Framing checks:
  - in_last on a beat other than BEATS-1: frame_err=1, counter resets to 0, state stays FILL. The partial frame is discarded; its samples are overwritten by the next frame.
  - in_last=0 on beat BEATS-1: frame_err=1, but the frame is still delivered (HOLD).
  - frame_err stays set until cleared by frame_ack.
- Simultaneous events:
  - The final beat and a stray frame_ack in the same cycle: ack is ignored (state was FILL).
  - frame_ack and in_valid in the same HOLD cycle: no beat is accepted that cycle.
- Reset asserted mid-FILL or mid-HOLD returns all outputs to reset values immediately, without waiting for clk. The partial frame is lost.

Test Plan:
1. Reset then stream 288 beats, all samples 8'sd3, in_last on beat 287 -> in_ready=1 one cycle after reset release; frame_valid=1 after beat 287; llr = 2304 copies of 8'h03; frame_err=0; sat_cnt=0.
2. Beat containing +300, -300, +127, -128, -127, 0, 5, -5 (in_w=12) -> stored 127, -127, 127, -127, -127, 0, 5, -5 at indices 0..7; sat_cnt=3.
3. Frame complete, hold frame_ack=0 for 50 cycles while driving in_valid=1 -> in_ready=0, llr unchanged. Pulse frame_ack -> next cycle frame_valid=0, in_ready=1; the next beat lands at indices 0..7.
4. in_last asserted on beat 10 -> frame_err=1, counter back to 0, no frame_valid. A following 288-beat correct frame gives frame_valid=1; frame_ack clears frame_err.
5. Final beat without in_last -> frame_valid=1 and frame_err=1 together.
6. Drive rst low mid-frame (beat 100), asynchronous to clk -> in_ready, frame_valid, frame_err, sat_cnt and llr go to zero immediately. After release, a full 288-beat frame is required for frame_valid.
